// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encodings, parity types, legal Prescale values and a majority helper.
// Pure declarations; no logic, latency or flow control.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        RX_IDLE   = ST_IDLE,
        RX_START  = ST_START,
        RX_DATA   = ST_DATA,
        RX_PARITY = ST_PARITY,
        RX_STOP   = ST_STOP
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter (0..prescale-1) and bit counter; wrap pulses on the last edge of each bit.
// Combinational wrap, counters update next clock; no backpressure.
module uart_rx_edge_bit_cnt #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]      bit_cnt,
    output logic                  wrap
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt_d, edge_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_d, bit_cnt_q;

    assign wrap     = en && (edge_cnt_q == prescale - ONE);
    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        // The start-detect cycle itself counts as edge 0.
        if (start) begin
            edge_cnt_d = ONE;
            bit_cnt_d  = '0;
        end else if (wrap) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        end else if (en) begin
            edge_cnt_d = edge_cnt_q + ONE;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX controller: oversampled start/data/parity/stop recovery; data_valid (1+DATA_WIDTH+PAR_EN+1)*Prescale clocks after start, no backpressure.
// UART_RX_MAJORITY_EN selects a 3-sample majority vote around mid-bit instead of a single mid-bit sample.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 3);

    rx_state_e             state_d, state_q;
    logic [PRESCALE_W-1:0] prescale_d, prescale_q;
    logic                  par_en_d, par_en_q;
    logic                  par_typ_d, par_typ_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic [DATA_WIDTH-1:0] p_data_d, p_data_q;
    logic                  sample_d, sample_q;
    logic                  data_valid_d, data_valid_q;
    logic                  par_err_d, par_err_q;
    logic                  stp_err_d, stp_err_q;
    logic                  busy_d, busy_q;

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  wrap;
    logic                  cnt_start;
    logic                  cnt_en;

    assign cnt_start = (state_q == RX_IDLE) && !RX_IN;
    assign cnt_en    = (state_q != RX_IDLE);
    assign half      = prescale_q >> 1;

    uart_rx_edge_bit_cnt #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_W      (BIT_W)
    ) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .start    (cnt_start),
        .en       (cnt_en),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .wrap     (wrap)
    );

`ifdef UART_RX_MAJORITY_EN
    logic maj_a_d, maj_a_q;
    logic maj_b_d, maj_b_q;

    always_comb begin
        sample_d = sample_q;
        maj_a_d  = maj_a_q;
        maj_b_d  = maj_b_q;
        if (cnt_en) begin
            if (edge_cnt == half - PRESCALE_W'(1)) maj_a_d = RX_IN;
            if (edge_cnt == half)                  maj_b_d = RX_IN;
            if (edge_cnt == half + PRESCALE_W'(1)) sample_d = maj3(maj_a_q, maj_b_q, RX_IN);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            maj_a_q <= 1'b1;
            maj_b_q <= 1'b1;
        end else begin
            maj_a_q <= maj_a_d;
            maj_b_q <= maj_b_d;
        end
    end
`else
    always_comb begin
        sample_d = sample_q;
        if (cnt_en && (edge_cnt == half)) sample_d = RX_IN;
    end
`endif

    always_comb begin
        state_d      = state_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        busy_d       = busy_q;
        case (state_q)
            RX_IDLE: begin
                if (!RX_IN) begin
                    state_d    = RX_START;
                    prescale_d = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RX_START: begin
                if (wrap) begin
                    state_d = sample_q ? RX_IDLE : RX_DATA;
                    busy_d  = !sample_q;
                end
            end
            RX_DATA: begin
                if (wrap) begin
                    shift_d = {sample_q, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt == BIT_W'(DATA_WIDTH)) state_d = par_en_q ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (wrap) begin
                    if (sample_q != (^shift_q ^ (par_typ_q == PAR_ODD))) par_err_d = 1'b1;
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (wrap) begin
                    state_d = RX_IDLE;
                    busy_d  = 1'b0;
                    if (!sample_q) begin
                        stp_err_d = 1'b1;
                    end else if (!par_err_q) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= RX_IDLE;
            prescale_q   <= PRESCALE_W'(PRESCALE_8);
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            shift_q      <= '0;
            p_data_q     <= '0;
            sample_q     <= 1'b1;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            sample_q     <= sample_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: hand-built serial frames, strobe timing and error flags.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int strobe_cyc[$];
    logic [7:0] strobe_dat[$];

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (data_valid === 1'b1) begin
            strobe_cyc.push_back(cyc);
            strobe_dat.push_back(P_DATA);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        RX_IN = b;
        tick(n);
    endtask

    task automatic clear_strobes();
        strobe_cyc.delete();
        strobe_dat.delete();
    endtask

    task automatic do_reset();
        RST   = 1'b0;
        RX_IN = 1'b1;
        tick(3);
        RST = 1'b1;
        tick(2);
    endtask

    // glitch: data bit index whose mid-bit sample cycle is inverted for one clock (-1 = none)
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic sbit, input int p, input int glitch);
        Prescale  = 6'(p);
        PAR_EN    = pen;
        start_cyc = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch) begin
                drive_bit(d[i], p / 2);
                drive_bit(~d[i], 1);
                drive_bit(d[i], p - p / 2 - 1);
            end else begin
                drive_bit(d[i], p);
            end
        end
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic test_reset();
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        tick(3);
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h expected 00", P_DATA); end
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err: got %b expected 0", par_err); end
        checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL reset_stp_err: got %b expected 0", stp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        RST = 1'b1;
        tick(2);
    endtask

    task automatic test_parity_good();
        int lat;
        clear_strobes();
        PAR_TYP = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8, -1);
        tick(2);
        lat = (strobe_cyc.size() > 0) ? strobe_cyc[0] - start_cyc : -1;
        checks++; if (strobe_cyc.size() != 1) begin errors++; $display("FAIL par_good_strobes: got %0d expected 1", strobe_cyc.size()); end
        checks++; if (lat != 88) begin errors++; $display("FAIL par_good_latency: got %0d expected 88", lat); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL par_good_data: got %h expected a5", P_DATA); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_good_par_err: got %b expected 0", par_err); end
        checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL par_good_stp_err: got %b expected 0", stp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_good_busy: got %b expected 0", busy); end
    endtask

    task automatic test_parity_err();
        do_reset();
        clear_strobes();
        PAR_TYP = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 8, -1);
        tick(2);
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_err_flag: got %b expected 1", par_err); end
        checks++; if (strobe_cyc.size() != 0) begin errors++; $display("FAIL par_err_strobes: got %0d expected 0", strobe_cyc.size()); end
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL par_err_data: got %h expected 00", P_DATA); end
    endtask

    task automatic test_stop_err();
        clear_strobes();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 16, -1);
        drive_bit(1'b1, 4);
        checks++; if (stp_err !== 1'b1) begin errors++; $display("FAIL stp_err_flag: got %b expected 1", stp_err); end
        checks++; if (strobe_cyc.size() != 0) begin errors++; $display("FAIL stp_err_strobes: got %0d expected 0", strobe_cyc.size()); end
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL stp_err_data: got %h expected 00", P_DATA); end
        clear_strobes();
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 16, -1);
        tick(2);
        checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL stp_recover_flag: got %b expected 0", stp_err); end
        checks++; if (strobe_cyc.size() != 1) begin errors++; $display("FAIL stp_recover_strobes: got %0d expected 1", strobe_cyc.size()); end
        checks++; if (P_DATA !== 8'h81) begin errors++; $display("FAIL stp_recover_data: got %h expected 81", P_DATA); end
    endtask

    task automatic test_false_start();
        clear_strobes();
        Prescale = 6'd8;
        RX_IN    = 1'b0;
        tick(3);
        RX_IN = 1'b1;
        tick(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_busy_mid: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_busy_end: got %b expected 0", busy); end
        tick(8);
        checks++; if (strobe_cyc.size() != 0) begin errors++; $display("FAIL false_strobes: got %0d expected 0", strobe_cyc.size()); end
        checks++; if ({par_err, stp_err} !== 2'b00) begin errors++; $display("FAIL false_flags: got %b expected 00", {par_err, stp_err}); end
    endtask

    task automatic test_back_to_back();
        int gap;
        clear_strobes();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 16, -1);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 16, -1);
        tick(2);
        checks++; if (strobe_cyc.size() != 2) begin errors++; $display("FAIL b2b_strobes: got %0d expected 2", strobe_cyc.size()); end
        if (strobe_cyc.size() == 2) begin
            gap = strobe_cyc[1] - strobe_cyc[0];
            checks++; if (gap != 160) begin errors++; $display("FAIL b2b_gap: got %0d expected 160", gap); end
            checks++; if (strobe_dat[0] !== 8'h3C) begin errors++; $display("FAIL b2b_data0: got %h expected 3c", strobe_dat[0]); end
            checks++; if (strobe_dat[1] !== 8'hC3) begin errors++; $display("FAIL b2b_data1: got %h expected c3", strobe_dat[1]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] partial;
        partial = 8'hFF;
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 8, -1);
        tick(2);
        Prescale = 6'd8;
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], 8);
        drive_bit(partial[4], 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        RST = 1'b0;
        #1;
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL mid_p_data: got %h expected 00", P_DATA); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if ({data_valid, par_err, stp_err} !== 3'b000) begin errors++; $display("FAIL mid_flags: got %b expected 000", {data_valid, par_err, stp_err}); end
        tick(2);
        RST   = 1'b1;
        RX_IN = 1'b1;
        tick(3);
        clear_strobes();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8, -1);
        tick(2);
        checks++; if (strobe_cyc.size() != 1) begin errors++; $display("FAIL mid_after_strobes: got %0d expected 1", strobe_cyc.size()); end
        checks++; if (P_DATA !== 8'h5A) begin errors++; $display("FAIL mid_after_data: got %h expected 5a", P_DATA); end
    endtask

    task automatic test_glitch();
        logic [7:0] exp_dat;
`ifdef UART_RX_MAJORITY_EN
        exp_dat = 8'h55;
`else
        exp_dat = 8'h51;
`endif
        clear_strobes();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 16, 2);
        tick(2);
        checks++; if (strobe_cyc.size() != 1) begin errors++; $display("FAIL glitch_strobes: got %0d expected 1", strobe_cyc.size()); end
        checks++; if (P_DATA !== exp_dat) begin errors++; $display("FAIL glitch_data: got %h expected %h", P_DATA, exp_dat); end
    endtask

    initial begin
        test_reset();
        test_parity_good();
        test_parity_err();
        test_stop_err();
        test_false_start();
        test_back_to_back();
        test_reset_mid();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
